// File: rtl/voice_pkg.sv
// Shared constants, parser state type and note-key lookup for the voice allocator.
package voice_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } ps2_state_e;

    function automatic logic is_note_key(input logic [7:0] code);
        case (code)
            8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
            8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B:
                is_note_key = 1'b1;
            default: is_note_key = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_prefix_parser.sv
// PS/2 prefix parser: tracks F0/E0 prefixes and flags plain make and break bytes.
module ps2_prefix_parser
    import voice_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic       make_valid,
    output logic       break_valid,
    output logic [7:0] code
);

    ps2_state_e state_q, state_d;

    assign code = code_in;

    // Strobes are decoded in the byte's own cycle so the voice table registers them
    // on the very next edge.
    always_comb begin
        state_d     = state_q;
        make_valid  = 1'b0;
        break_valid = 1'b0;
        if (code_valid) begin
            if (code_in == SC_ERR_LO || code_in == SC_ERR_HI) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (code_in == SC_BREAK) begin
                            state_d = StBrk;
                        end else if (code_in == SC_EXT) begin
                            state_d = StExt;
                        end else begin
                            make_valid = 1'b1;
                        end
                    end
                    StBrk: begin
                        break_valid = 1'b1;
                        state_d     = StIdle;
                    end
                    StExt:    state_d = (code_in == SC_BREAK) ? StExtBrk : StIdle;
                    StExtBrk: state_d = StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps held PS/2 note keys onto NUM_VOICES scan-code channels.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping when all are busy.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              code_in,
    input  logic                    code_valid,
    output logic [8*NUM_VOICES-1:0] voice_code,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    note_on,
    output logic                    note_off,
    output logic [2:0]              event_voice,
    output logic                    drop
);

    logic       make_valid, break_valid;
    logic [7:0] pcode;

    ps2_prefix_parser u_parser (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .make_valid (make_valid),
        .break_valid(break_valid),
        .code       (pcode)
    );

`ifdef VOICE_STEAL_EN
    localparam logic [2:0] RankMax = 3'(NUM_VOICES - 1);
`endif

    logic [NUM_VOICES-1:0][7:0] code_q, code_d;
    logic [NUM_VOICES-1:0][2:0] rank_q, rank_d;
    logic [NUM_VOICES-1:0]      active_q, active_d;
    logic                       note_on_q, note_on_d, note_off_q, note_off_d, drop_q, drop_d;
    logic [2:0]                 event_voice_q, event_voice_d;

    logic       hit, free;
    logic [2:0] hit_idx, hit_rank, free_idx, n_active;

    always_comb begin
        code_d        = code_q;
        rank_d        = rank_q;
        active_d      = active_q;
        note_on_d     = 1'b0;
        note_off_d    = 1'b0;
        drop_d        = 1'b0;
        event_voice_d = event_voice_q;
        hit           = 1'b0;
        hit_idx       = '0;
        hit_rank      = '0;
        free          = 1'b0;
        free_idx      = '0;
        n_active      = '0;

        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (active_q[i]) begin
                n_active = n_active + 3'd1;
                if (code_q[i] == pcode) begin
                    hit      = 1'b1;
                    hit_idx  = 3'(i);
                    hit_rank = rank_q[i];
                end
            end else if (!free) begin
                free     = 1'b1;
                free_idx = 3'(i);
            end
        end

        if (make_valid && is_note_key(pcode)) begin
            // A make for a code already sounding is typematic repeat.
            if (!hit) begin
                if (free) begin
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (3'(i) == free_idx) begin
                            code_d[i]   = pcode;
                            active_d[i] = 1'b1;
                            rank_d[i]   = n_active;
                        end
                    end
                    note_on_d     = 1'b1;
                    event_voice_d = free_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (rank_q[i] == '0) begin
                            code_d[i]     = pcode;
                            rank_d[i]     = RankMax;
                            event_voice_d = 3'(i);
                        end else begin
                            rank_d[i] = rank_q[i] - 3'd1;
                        end
                    end
                    note_on_d = 1'b1;
`else
                    drop_d = 1'b1;
`endif
                end
            end
        end else if (break_valid && is_note_key(pcode) && hit) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                if (3'(i) == hit_idx) begin
                    code_d[i]   = SC_BREAK;
                    active_d[i] = 1'b0;
                    rank_d[i]   = '0;
                end else if (active_q[i] && rank_q[i] > hit_rank) begin
                    rank_d[i] = rank_q[i] - 3'd1;
                end
            end
            note_off_d    = 1'b1;
            event_voice_d = hit_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q        <= {NUM_VOICES{SC_BREAK}};
            rank_q        <= '0;
            active_q      <= '0;
            note_on_q     <= 1'b0;
            note_off_q    <= 1'b0;
            drop_q        <= 1'b0;
            event_voice_q <= '0;
        end else begin
            code_q        <= code_d;
            rank_q        <= rank_d;
            active_q      <= active_d;
            note_on_q     <= note_on_d;
            note_off_q    <= note_off_d;
            drop_q        <= drop_d;
            event_voice_q <= event_voice_d;
        end
    end

    assign voice_code   = code_q;
    assign voice_active = active_q;
    assign note_on      = note_on_q;
    assign note_off     = note_off_q;
    assign drop         = drop_q;
    assign event_voice  = event_voice_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: reference model tracks held notes by voice and age.
module tb_voice_allocator;

    localparam int NV      = 4;
    localparam int EV_ON   = 1;
    localparam int EV_OFF  = 2;
    localparam int EV_DROP = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      code_in = 8'h00;
    logic            code_valid = 1'b0;
    logic [8*NV-1:0] voice_code;
    logic [NV-1:0]   voice_active;
    logic            note_on, note_off, drop;
    logic [2:0]      event_voice;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk         (clk),
        .reset       (reset),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .voice_code  (voice_code),
        .voice_active(voice_active),
        .note_on     (note_on),
        .note_off    (note_off),
        .event_voice (event_voice),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              kind;
        int              idx;
        logic [8*NV-1:0] vc;
        logic [NV-1:0]   act;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] notes[20] = '{8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                              8'h35, 8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C,
                              8'h52, 8'h5B};

    // Model: code held by each voice (F0 = idle) and voice indices in age order, oldest first.
    logic [7:0] m_vc[NV];
    int         age_q[$];
    int         pst;

    function automatic bit is_note(input logic [7:0] c);
        foreach (notes[i]) if (notes[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8*NV-1:0] m_pack();
        logic [8*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[8*i +: 8] = m_vc[i];
        return r;
    endfunction

    function automatic logic [NV-1:0] m_act();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = (m_vc[i] != 8'hF0);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) m_vc[i] = 8'hF0;
        age_q.delete();
        exp_q.delete();
        pst = 0;
    endfunction

    function automatic void push_ev(input int kind, input int idx);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.vc   = m_pack();
        e.act  = m_act();
        exp_q.push_back(e);
    endfunction

    function automatic void model_make(input logic [7:0] c);
        if (!is_note(c)) return;
        for (int i = 0; i < NV; i++) if (m_vc[i] == c) return;
        for (int i = 0; i < NV; i++) begin
            if (m_vc[i] == 8'hF0) begin
                m_vc[i] = c;
                age_q.push_back(i);
                push_ev(EV_ON, i);
                return;
            end
        end
`ifdef VOICE_STEAL_EN
        begin
            int v;
            v = age_q.pop_front();
            m_vc[v] = c;
            age_q.push_back(v);
            push_ev(EV_ON, v);
        end
`else
        push_ev(EV_DROP, 0);
`endif
    endfunction

    function automatic void model_break(input logic [7:0] c);
        if (!is_note(c)) return;
        for (int i = 0; i < NV; i++) begin
            if (m_vc[i] == c) begin
                int k;
                k = -1;
                foreach (age_q[j]) if (age_q[j] == i) k = j;
                if (k >= 0) age_q.delete(k);
                m_vc[i] = 8'hF0;
                push_ev(EV_OFF, i);
                return;
            end
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h00 || b == 8'hFF) begin
            pst = 0;
        end else begin
            case (pst)
                0: begin
                    if (b == 8'hF0) pst = 1;
                    else if (b == 8'hE0) pst = 2;
                    else model_make(b);
                end
                1: begin
                    model_break(b);
                    pst = 0;
                end
                2: pst = (b == 8'hF0) ? 3 : 0;
                default: pst = 0;
            endcase
        end
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code_in    = b;
        code_valid = 1'b1;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            code_valid = 1'b0;
        end
    endtask

    task automatic check_state(input string name);
        idle(2);
        tests++;
        if (voice_code !== m_pack() || voice_active !== m_act() || exp_q.size() != 0
            || note_on || note_off || drop) begin
            fails++;
            $display("FAIL %s: got code=%h act=%b strobes=%b%b%b pending=%0d, expected code=%h act=%b strobes=000 pending=0",
                     name, voice_code, voice_active, note_on, note_off, drop, exp_q.size(),
                     m_pack(), m_act());
        end
    endtask

    task automatic check_const(input string name, input logic [8*NV-1:0] vc,
                               input logic [NV-1:0] act);
        tests++;
        if (voice_code !== vc || voice_active !== act) begin
            fails++;
            $display("FAIL %s: got code=%h act=%b, expected code=%h act=%b",
                     name, voice_code, voice_active, vc, act);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        code_valid = 1'b0;
        reset      = 1'b1;
        model_reset();
        #1;
        tests++;
        if (voice_code !== {NV{8'hF0}} || voice_active !== '0 || note_on || note_off || drop
            || event_voice !== 3'd0) begin
            fails++;
            $display("FAIL reset: got code=%h act=%b on=%b off=%b drop=%b ev=%0d, expected all idle",
                     voice_code, voice_active, note_on, note_off, drop, event_voice);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every strobe must match the next expected event, including post-event voice state.
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && (note_on || note_off || drop)) begin
            if (int'(note_on) + int'(note_off) + int'(drop) > 1) mon_kind = 4;
            else if (note_on) mon_kind = EV_ON;
            else if (note_off) mon_kind = EV_OFF;
            else mon_kind = EV_DROP;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL strobe_unexpected: got kind=%0d voice=%0d, expected no event",
                         mon_kind, event_voice);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_kind != mon_e.kind
                    || (mon_e.kind != EV_DROP && event_voice !== 3'(mon_e.idx))
                    || voice_code !== mon_e.vc || voice_active !== mon_e.act) begin
                    fails++;
                    $display("FAIL event: got kind=%0d voice=%0d code=%h act=%b, expected kind=%0d voice=%0d code=%h act=%b",
                             mon_kind, event_voice, voice_code, voice_active,
                             mon_e.kind, mon_e.idx, mon_e.vc, mon_e.act);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        model_reset();
        do_reset();
        check_state("idle_after_reset");
        check_const("idle_const", 32'hF0F0F0F0, 4'b0000);

        send(8'h1C); send(8'h2B);
        check_state("two_notes");
        check_const("two_notes_const", 32'hF0F02B1C, 4'b0011);

        send(8'h34); send(8'h33); send(8'h42);
        check_state("full_then_42");

        do_reset();
        send(8'h1C); send(8'h2B); send(8'h34); send(8'h33);
        send(8'hF0); send(8'h2B);
        check_state("release_voice1");
        check_const("release_const", 32'h3334F01C, 4'b1101);
        send(8'h4B);
        check_state("refill_voice1");
        check_const("refill_const", 32'h33344B1C, 4'b1111);

        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h5B);
        check_state("typematic_and_unheld_break");

        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h1C);
        send(8'h29); send(8'hF0); send(8'h29);
        check_state("ignored_inputs");

        do_reset();
        send(8'hF0); send(8'h00); send(8'h1C);
        check_state("error_byte_resync");

        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h2B);
        check_state("reset_mid_break");

        do_reset();
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) b = notes[$urandom_range(0, 7)];
            else if (r < 65) b = 8'hF0;
            else if (r < 72) b = 8'hE0;
            else if (r < 74) b = 8'h00;
            else if (r < 75) b = 8'hFF;
            else if (r < 85) b = notes[$urandom_range(8, 19)];
            else b = 8'($urandom_range(1, 254));
            send(b);
            if ($urandom_range(0, 9) == 0) idle(1);
            if (n % 50 == 49) check_state("random");
        end
        check_state("random_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
